// File: rtl/uart_cmd_link_ctrl.sv
// uart_cmd_link_ctrl: round-robin command/ack sequencer over a shared uart_tx/uart_rx pair.
// Optional statistics counters: define UART_LINK_STATS_EN.
module uart_cmd_link_ctrl #(
    parameter int         NUM_REQ     = 2,
    parameter logic [7:0] ACK_CODE    = 8'h3C,
    parameter int         TIMEOUT_CYC = 2400,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   fail,
    output logic                 busy,
    output logic [7:0]           data_to_tx,
    output logic                 start_tx,
    input  logic                 tx_busy,
    input  logic [7:0]           data_received,
    input  logic                 rx_done,
    input  logic                 parity_error
`ifdef UART_LINK_STATS_EN
    ,
    output logic [15:0]          retry_count,
    output logic [15:0]          fail_count,
    output logic [15:0]          stray_count
`endif
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {IDLE, SEND, TX_ARM, TX_WAIT, ACK_WAIT, FINISH} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       idx, rr, pick, cand;
    logic                found, ok, rsp_good, err;
    logic [TW-1:0]       timer;
    logic [RW-1:0]       retry;
    logic [NUM_REQ-1:0]  onehot;
    int                  j;

    always_comb begin
        pick  = rr;
        found = 1'b0;
        j     = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = IW'(j);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // A received byte always takes priority over a coincident timeout
    assign rsp_good = rx_done && !parity_error && data_received == ACK_CODE;
    assign err      = rx_done ? !rsp_good : timer == TW'(TIMEOUT_CYC - 1);
    assign onehot   = NUM_REQ'(1) << idx;
    assign start_tx = state == SEND;
    assign busy     = state != IDLE;
    assign grant    = busy ? onehot : '0;
    assign done     = (state == FINISH && ok) ? onehot : '0;
    assign fail     = (state == FINISH && !ok) ? onehot : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = |req ? SEND : IDLE;
            SEND:     state_nx = TX_ARM;
            TX_ARM:   state_nx = TX_WAIT;
            TX_WAIT:  state_nx = tx_busy ? TX_WAIT : ACK_WAIT;
            ACK_WAIT: state_nx = rsp_good ? FINISH :
                                 !err ? ACK_WAIT :
                                 retry < RW'(MAX_RETRY) ? SEND : FINISH;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            rr         <= '0;
            data_to_tx <= '0;
            retry      <= '0;
            timer      <= '0;
            ok         <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                idx        <= pick;
                data_to_tx <= req_cmd[8*pick +: 8];
                retry      <= '0;
            end
            if (state == TX_WAIT && !tx_busy) timer <= '0;
            if (state == ACK_WAIT) begin
                timer <= timer + 1'b1;
                ok    <= rsp_good;
                if (state_nx == SEND) retry <= retry + 1'b1;
            end
            if (state == FINISH) rr <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

`ifdef UART_LINK_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_count <= '0;
            fail_count  <= '0;
            stray_count <= '0;
        end else begin
            if (state == ACK_WAIT && state_nx == SEND && retry_count != 16'hFFFF)
                retry_count <= retry_count + 1'b1;
            if (state == FINISH && !ok && fail_count != 16'hFFFF)
                fail_count <= fail_count + 1'b1;
            if (rx_done && state != ACK_WAIT && stray_count != 16'hFFFF)
                stray_count <= stray_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_cmd_link_ctrl.sv
// tb_uart_cmd_link_ctrl: directed self-checking bench for uart_cmd_link_ctrl (default parameters).
module tb_uart_cmd_link_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] req_cmd = {8'hA5, 8'h9D};
    logic        tx_busy = 1'b0, rx_done = 1'b0, parity_error = 1'b0;
    logic [7:0]  data_received = '0;
    logic [1:0]  grant, done, fail;
    logic        busy, start_tx;
    logic [7:0]  data_to_tx;
`ifdef UART_LINK_STATS_EN
    logic [15:0] retry_count, fail_count, stray_count;
`endif
    int vectors = 0, miscompares = 0, n;
    logic [1:0] exp_g;

    uart_cmd_link_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd),
        .grant(grant), .done(done), .fail(fail), .busy(busy),
        .data_to_tx(data_to_tx), .start_tx(start_tx), .tx_busy(tx_busy),
        .data_received(data_received), .rx_done(rx_done), .parity_error(parity_error)
`ifdef UART_LINK_STATS_EN
        , .retry_count(retry_count), .fail_count(fail_count), .stray_count(stray_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the SEND edge; leaves the DUT in ACK_WAIT with timer=0
    task automatic tx_phase();
        tick();
        chk("start_single", start_tx, 0);
        tx_busy = 1'b1;
        repeat (4) tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic respond(input logic [7:0] d, input logic p);
        tick();
        rx_done = 1'b1;
        data_received = d;
        parity_error = p;
        tick();
        rx_done = 1'b0;
        parity_error = 1'b0;
    endtask

    task automatic wait_timeout(output int cnt);
        cnt = 0;
        while (!start_tx && fail == 2'b00 && cnt < 5000) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_tx, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_data", data_to_tx, 0);

        req = 2'b01;
        tick();
        chk("basic_start", start_tx, 1);
        chk("basic_data", data_to_tx, 8'h9D);
        chk("basic_grant", grant, 2'b01);
        tx_phase();
        chk("basic_busy", busy, 1);
        respond(8'h3C, 1'b0);
        chk("basic_done", done, 2'b01);
        chk("basic_nofail", fail, 0);
        req = 2'b00;
        tick();
        chk("basic_done_clr", done, 0);
        chk("basic_idle", busy, 0);
        chk("basic_data_hold", data_to_tx, 8'h9D);

        req = 2'b01;
        tick();
        chk("retry_grant", grant, 2'b01);
        tx_phase();
        respond(8'h55, 1'b0);
        chk("retry_resend", start_tx, 1);
        chk("retry_data", data_to_tx, 8'h9D);
        chk("retry_nodone", done, 0);
        tx_phase();
        respond(8'h3C, 1'b0);
        chk("retry_done", done, 2'b01);
        req = 2'b00;
        tick();

        req = 2'b01;
        tick();
        chk("to_start", start_tx, 1);
        tx_phase();
        for (int a = 0; a < 4; a++) begin
            wait_timeout(n);
            chk("to_spacing", n, 2400);
            if (a < 3) begin
                chk("to_resend", start_tx, 1);
                tx_phase();
            end else begin
                chk("to_fail", fail, 2'b01);
                chk("to_nodone", done, 0);
            end
        end
        req = 2'b00;
        tick();
        chk("to_fail_clr", fail, 0);
`ifdef UART_LINK_STATS_EN
        chk("st_retry", retry_count, 4);
        chk("st_fail", fail_count, 1);
`endif

        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            chk("rr_grant", grant, exp_g);
            chk("rr_data", data_to_tx, exp_g == 2'b10 ? 8'hA5 : 8'h9D);
            if (i == 1) req_cmd = {8'hA5, 8'h11};
            tx_phase();
            chk("rr_cmd_latched", data_to_tx, exp_g == 2'b10 ? 8'hA5 : 8'h9D);
            req_cmd = {8'hA5, 8'h9D};
            respond(8'h3C, 1'b0);
            chk("rr_done", done, exp_g);
            if (i == 3) req = 2'b00;
            tick();
        end

        req = 2'b01;
        tick();
        chk("par_grant", grant, 2'b01);
        tx_phase();
        respond(8'h3C, 1'b1);
        chk("par_retry", start_tx, 1);
        chk("par_nodone", done, 0);
        tx_phase();
        repeat (2399) tick();
        rx_done = 1'b1;
        data_received = 8'h3C;
        tick();
        rx_done = 1'b0;
        chk("race_done", done, 2'b01);
        chk("race_noretry", start_tx, 0);
        req = 2'b00;
        tick();

        rx_done = 1'b1;
        data_received = 8'h3C;
        tick();
        rx_done = 1'b0;
        chk("stray_idle", busy, 0);
        tick();
        chk("stray_nodone", done, 0);
`ifdef UART_LINK_STATS_EN
        chk("st_stray", stray_count, 1);
        chk("st_retry2", retry_count, 5);
`endif

        req = 2'b10;
        tick();
        chk("arst_pre_grant", grant, 2'b10);
        tx_phase();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_start", start_tx, 0);
        chk("arst_done", done, 0);
        chk("arst_fail", fail, 0);
        tick();
        reset = 1'b0;
        req = 2'b11;
        tick();
        chk("arst_rr0", grant, 2'b01);
        chk("arst_data", data_to_tx, 8'h9D);
        tx_phase();
        respond(8'h3C, 1'b0);
        chk("arst_done_after", done, 2'b01);
        req = 2'b00;
        tick();
`ifdef UART_LINK_STATS_EN
        chk("st_rst_retry", retry_count, 0);
        chk("st_rst_fail", fail_count, 0);
        chk("st_rst_stray", stray_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_cmd_link_ctrl.md
Name: uart_cmd_link_ctrl

Overview:
- Sequences the shared uart_tx/uart_rx pair as a command/acknowledge link.
- Arbitrates round-robin among NUM_REQ requesters, each wanting to send one command byte (e.g. 8'h9D toggle).
- Sends the byte, waits for the ack byte (8'h3C) with a timeout, and retries a bounded number of times.
- Sits between gate-control logic and the UART modules in the top level.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ACK_CODE, 8'h3C, byte the far end returns on success.
- TIMEOUT_CYC, 2400, clk cycles to wait for ack (100 us at 24 MHz).
- MAX_RETRY, 3, resends allowed after the first attempt.

Ports:
- clk  in  1  system clock (24 MHz HFOSC).
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until that requester's done or fail.
- req_cmd  in  8*NUM_REQ  command byte per requester; byte i is [8i+7:8i].
- grant  out  NUM_REQ  one-hot, high while the transaction for that requester is in progress.
- done  out  NUM_REQ  one-cycle pulse: ack received.
- fail  out  NUM_REQ  one-cycle pulse: retries exhausted.
- busy  out  1  high in any state except IDLE.
- data_to_tx  out  8  to uart_tx.
- start_tx  out  1  to uart_tx; one-cycle pulse.
- tx_busy  in  1  from uart_tx.
- data_received  in  8  from uart_rx.
- rx_done  in  1  from uart_rx; one-cycle pulse.
- parity_error  in  1  from uart_rx; valid with rx_done.

Behaviour:
- Reset values (async): state=IDLE; grant=0, done=0, fail=0, busy=0, start_tx=0, data_to_tx=0; rr pointer=0; retry count=0; timer=0.
- Reset mid-transaction aborts immediately. No done/fail is issued. A start_tx in flight is dropped.
- States: IDLE, SEND, TX_ARM, TX_WAIT, ACK_WAIT, FINISH.
- IDLE:
  - On an edge where req!=0, pick the first set bit searching upward from rr pointer, wrapping.
  - Latch its index and req_cmd byte into data_to_tx; set grant bit; retry=0.
  - Go to SEND.
- SEND: start_tx=1 for exactly this cycle. Go to TX_ARM.
  - start_tx is high in the cycle after req is first seen in IDLE.
- TX_ARM: one guard cycle so uart_tx can raise tx_busy. Go to TX_WAIT.
- TX_WAIT: when tx_busy=0, clear timer and go to ACK_WAIT.
- ACK_WAIT: timer increments every cycle.
  - Success: rx_done=1, parity_error=0 and data_received==ACK_CODE -> FINISH with success.
  - Bad response: rx_done=1 with a wrong byte or parity_error=1 -> treated as an error.
  - Timeout: timer==TIMEOUT_CYC-1 with no rx_done -> treated as an error.
  - On an error: if retry<MAX_RETRY, retry+=1 and go to SEND (data_to_tx unchanged); else FINISH with failure.
  - rx_done and timeout in the same cycle: rx_done is evaluated and timeout is ignored.
- FINISH: pulse done[i] or fail[i] for one cycle; clear grant; rr pointer=(i+1) mod NUM_REQ; go to IDLE.
  - IDLE may grant again on the very next edge.
- data_to_tx holds the latched byte from grant until the next grant. It is not cleared in IDLE.
- rx_done outside ACK_WAIT is ignored (stray byte). It never completes a later transaction.
- Requester behaviour:
  - A requester dropping req mid-transaction is ignored; the transaction completes normally.
  - req_cmd changes after grant are ignored.
- Widths:
  - Timer width is clog2(TIMEOUT_CYC)+1.
  - Retry counter width is clog2(MAX_RETRY+1).
  - The counters never wrap: the timer is cleared on each SEND→ACK_WAIT entry.
- Worst-case transaction: (MAX_RETRY+1) × (TX time + TIMEOUT_CYC + 3) cycles.

Optional Feature:
- Macro: UART_LINK_STATS_EN.
- Defined: adds outputs retry_count[15:0] and fail_count[15:0] and stray_count[15:0].
  - retry_count: total resends.
  - fail_count: total fail pulses.
  - stray_count: rx_done seen outside ACK_WAIT.
  - All three saturate at 16'hFFFF and are cleared only by reset.
- Not defined: these ports and their counters do not exist. Core behaviour is identical.

Test Plan:
- Basic ack: req=2'b01, cmd0=8'h9D; far end returns 8'h3C -> start_tx pulses once with data_to_tx=8'h9D; done[0] pulses once; fail=0; rr pointer=1.
- Retry then success: first response 8'h55, second response 8'h3C -> exactly 2 start_tx pulses, then done[0].
- Timeout exhaustion: no response, MAX_RETRY=3, TIMEOUT_CYC=2400 -> 4 start_tx pulses spaced ≥2400 cycles apart, then fail[0]; fail_count=1 and retry_count=3 with UART_LINK_STATS_EN.
- Fairness: req=2'b11 held continuously, all acks good -> grant sequence 0,1,0,1; data_to_tx alternates cmd0/cmd1.
- Corner events:
  - Parity_error=1 on a 8'h3C response -> treated as an error (retry).
  - rx_done=8'h3C in the same cycle as timeout -> done.
  - Stray rx_done in IDLE -> no done; stray_count=1.
- Async reset asserted in ACK_WAIT -> grant, busy and start_tx are 0 immediately (before the next clk edge); no done/fail; the next req is granted from index 0.
